// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: prioritises interrupts and per-instruction
// exceptions, reports one encoded exception to CP0 and drives flush/redirect.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_exc_flags,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr,
  input  logic [31:0] wb_cp0_wdata,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] newpc_q, newpc_d;

  logic [31:0] status_f;
  logic [31:0] epc_f;
  logic [7:0]  ip_f;
  logic        int_pending;
  logic        cand_valid;
  logic [31:0] cand_type;
  logic [31:0] cand_bad;
  logic [31:0] cand_newpc;
  logic        unused_bits;

  always_comb begin
    status_f = cp0_status;
    if (wb_cp0_we && wb_cp0_waddr == 5'd12) status_f = wb_cp0_wdata;
    epc_f = cp0_epc;
    if (wb_cp0_we && wb_cp0_waddr == 5'd14) epc_f = wb_cp0_wdata;
    // only the software interrupt bits of Cause are writable by mtc0
    ip_f = cp0_cause[15:8];
    if (wb_cp0_we && wb_cp0_waddr == 5'd13) ip_f[1:0] = wb_cp0_wdata[9:8];

    int_pending = status_f[0] & ~status_f[1] & (|(ip_f & status_f[15:8]));
    unused_bits = ^{cp0_cause[31:16], cp0_cause[7:0], status_f[31:16], status_f[7:2]};

    cand_valid = 1'b0;
    cand_type  = '0;
    cand_bad   = '0;
    if (mem_valid) begin
      cand_valid = 1'b1;
      if (int_pending)           cand_type = 32'h1;
      else if (mem_exc_flags[0]) begin
        cand_type = 32'h4;
        cand_bad  = mem_pc;
      end
      else if (mem_exc_flags[1]) cand_type = 32'hA;
      else if (mem_exc_flags[2]) cand_type = 32'hC;
      else if (mem_exc_flags[3]) cand_type = 32'h8;
      else if (mem_exc_flags[4]) cand_type = 32'h9;
      else if (mem_exc_flags[5]) cand_type = 32'hE;
      else if (mem_exc_flags[6]) begin
        cand_type = 32'h4;
        cand_bad  = mem_addr;
      end
      else if (mem_exc_flags[7]) begin
        cand_type = 32'h5;
        cand_bad  = mem_addr;
      end
      else cand_valid = 1'b0;
    end
    cand_newpc = (cand_type == 32'hE) ? epc_f : EXC_VECTOR;
  end

  always_comb begin
    state_d             = state_q;
    newpc_d             = newpc_q;
    excepttype_o        = '0;
    current_inst_addr_o = '0;
    is_in_delayslot_o   = 1'b0;
    bad_addr_o          = '0;
    flush_o             = 1'b0;
    newpc_o             = '0;
    if (!rst) begin
      current_inst_addr_o = mem_pc;
      is_in_delayslot_o   = mem_in_delayslot;
      case (state_q)
        IDLE: begin
          if (cand_valid) begin
            excepttype_o = cand_type;
            bad_addr_o   = cand_bad;
            flush_o      = 1'b1;
            newpc_o      = cand_newpc;
            if (mem_stall) begin
              state_d = HOLD;
              newpc_d = cand_newpc;
            end
          end
        end
        HOLD: begin
          // CP0 was already updated on entry; only keep the pipeline flushed
          flush_o = 1'b1;
          newpc_o = newpc_q;
          if (!mem_stall) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      newpc_q <= '0;
    end else begin
      state_q <= state_d;
      newpc_q <= newpc_d;
    end
  end

endmodule
